vedic_mul_seq_ctrl: RTL and testbench
=====================================

# vedic_mul_seq_ctrl

Sequencing controller that computes an 8x8 unsigned product by time-sharing one combinational 4x4 Vedic multiplier core over four cycles. It captures two 8-bit operands on a start handshake and drives the core with one nibble pair per cycle. It shift-accumulates the four partial products and presents a registered 16-bit product with a one-cycle done pulse. It sits between the tile's I/O decode logic and the shared 4x4 core.

## Interface
- Parameters: none; widths fixed (8x8 operands, 16-bit product, 4x4 core).
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  clock enable; when 0, all registers hold.
- start  input  1  operation request; sampled only in IDLE with ena=1.
- a  input  8  multiplicand; captured on accept.
- b  input  8  multiplier; captured on accept.
- pp_a  output  4  nibble to the 4x4 core, A side.
- pp_b  output  4  nibble to the 4x4 core, B side.
- pp_p  input  8  combinational 4x4 core product of pp_a*pp_b, same cycle.
- busy  output  1  high in states PP0..PP3.
- done  output  1  registered one-cycle pulse marking a new product.
- product  output  16  last completed result; held until the next completion.

## Operation
- FSM states: IDLE, PP0, PP1, PP2, PP3.
- IDLE, start=1, ena=1: capture a->ra and b->rb, clear acc, go to PP0. Otherwise stay in IDLE.
- PP0: pp_a=ra[3:0], pp_b=rb[3:0]; acc <= pp_p. Go to PP1.
- PP1: pp_a=ra[7:4], pp_b=rb[3:0]; acc <= acc + (pp_p<<4). Go to PP2.
- PP2: pp_a=ra[3:0], pp_b=rb[7:4]; acc <= acc + (pp_p<<4). Go to PP3.
- PP3: pp_a=ra[7:4], pp_b=rb[7:4]; product <= acc + (pp_p<<8); done <= 1. Go to IDLE.
- In IDLE, pp_a=pp_b=0.
- Arithmetic: acc is 16-bit unsigned. The maximum result is 0xFF*0xFF = 0xFE01, so no overflow or truncation is possible.
- start while busy: ignored, not queued. Operands a and b may change freely after accept.
- done clears on the next enabled edge unless that edge ends another PP3 (not possible back-to-back).
- ena=0: state, acc, ra/rb, product and done all freeze. A pending done stays high until the next enabled edge. pp_a and pp_b keep following the frozen state.
- Reset (asynchronous, any time, including mid-operation): state=IDLE, ra=rb=0, acc=0, product=0x0000, done=0, busy=0, pp_a=pp_b=0. An in-flight operation is discarded with no done.

## Timing
- Accept edge E0 (IDLE, start=1, ena=1) -> busy=1 after E0.
- Edges E1..E4 complete PP0..PP3.
- After E4: product valid, done=1, busy=0.
- After E5: done=0.
- Latency from accept to done is 4 enabled edges.
- A start held high at E5 (IDLE while done=1) is accepted. Sustained throughput is one result per 5 enabled cycles.
- pp_a and pp_b are decoded from registered state and ra/rb only: glitch-free relative to a and b, combinational to the core only.
- pp_p must settle within one cycle. The core's delay is outside this block.
- Stalls with ena=0 stretch latency by exactly the number of disabled cycles.

## Test plan
- After reset release, start with a=0x03, b=0x02 -> done after 4 edges, product=0x0006; pp_a/pp_b sequence (3,2),(0,2),(3,0),(0,0).
- a=0xFF, b=0xFF -> product=0xFE01; then a=0x90, b=0x00 -> product=0x0000 with done pulsing.
- Hold start=1 continuously with operands 0x54*0x23 then 0x0F*0x11 -> done at E4 and E9; products 0x0B7C then 0x00FF. Busy pulses between them are ignored.
- Start 0x12*0x34, then assert rst_n=0 after E2 -> immediate IDLE, product=0, no done; the next start 0x02*0x05 gives 0x000A.
- Start 0xAB*0xCD with ena=0 for 3 cycles after E2 -> done 7 edges after accept, product=0x88EF; done held high while ena=0 at completion.
- Randomized 500 operand pairs against a reference a*b with a behavioral 4x4 core model -> all products match, with exactly one done per accepted start.

Source files
------------

// File: rtl/vedic_mul_seq_ctrl_if.sv
// Bundle between the I/O decode side (master) and the sequencing controller (slave),
// including the nibble path to the shared 4x4 core.
//   ena, start, a, b : request side, driven by master
//   pp_a, pp_b       : nibble pair to the 4x4 core, driven by controller
//   pp_p             : combinational 4x4 core product, same cycle
//   busy, done       : status; done is a registered one-cycle pulse
//   product          : last completed 16-bit result
interface vedic_mul_seq_ctrl_if;
    logic        ena;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  pp_a;
    logic [3:0]  pp_b;
    logic [7:0]  pp_p;
    logic        busy;
    logic        done;
    logic [15:0] product;

    modport master (
        output ena, start, a, b, pp_p,
        input  pp_a, pp_b, busy, done, product
    );

    modport slave (
        input  ena, start, a, b, pp_p,
        output pp_a, pp_b, busy, done, product
    );
endinterface

// File: rtl/vedic_mul_seq_ctrl.sv
// 8x8 unsigned multiplier built by time-sharing one 4x4 core over four cycles.
// Operands are captured on an accepted start; each PP state drives one nibble pair,
// and the partial products are shift-accumulated into a 16-bit result.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of vedic_mul_seq_ctrl_if (request, core nibbles, status, product)
module vedic_mul_seq_ctrl (
    input  logic                        clk,
    input  logic                        rst_n,
    vedic_mul_seq_ctrl_if.slave         bus
);

    typedef enum logic [2:0] {StIdle, StPp0, StPp1, StPp2, StPp3} state_e;

    state_e      state_q, state_d;
    logic [7:0]  ra_q, ra_d;
    logic [7:0]  rb_q, rb_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] product_q, product_d;
    logic        done_q, done_d;

    // Whole register set advances only on enabled edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ra_q      <= 8'h00;
            rb_q      <= 8'h00;
            acc_q     <= 16'h0000;
            product_q <= 16'h0000;
            done_q    <= 1'b0;
        end else if (bus.ena) begin
            state_q   <= state_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        acc_d     = acc_q;
        product_d = product_q;
        done_d    = 1'b0;
        bus.pp_a  = 4'h0;
        bus.pp_b  = 4'h0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    ra_d    = bus.a;
                    rb_d    = bus.b;
                    acc_d   = 16'h0000;
                    state_d = StPp0;
                end
            end
            StPp0: begin
                bus.pp_a = ra_q[3:0];
                bus.pp_b = rb_q[3:0];
                acc_d    = {8'h00, bus.pp_p};
                state_d  = StPp1;
            end
            StPp1: begin
                bus.pp_a = ra_q[7:4];
                bus.pp_b = rb_q[3:0];
                acc_d    = acc_q + {4'h0, bus.pp_p, 4'h0};
                state_d  = StPp2;
            end
            StPp2: begin
                bus.pp_a = ra_q[3:0];
                bus.pp_b = rb_q[7:4];
                acc_d    = acc_q + {4'h0, bus.pp_p, 4'h0};
                state_d  = StPp3;
            end
            StPp3: begin
                bus.pp_a  = ra_q[7:4];
                bus.pp_b  = rb_q[7:4];
                product_d = acc_q + {bus.pp_p, 8'h00};
                done_d    = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule

// File: tb/tb_vedic_mul_seq_ctrl.sv
// Directed bench for vedic_mul_seq_ctrl with a behavioural 4x4 core model.
module tb_vedic_mul_seq_ctrl;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    vedic_mul_seq_ctrl_if bus ();

    vedic_mul_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural 4x4 core.
    assign bus.pp_p = {4'h0, bus.pp_a} * {4'h0, bus.pp_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one start and wait (bounded) for done; reports edges after accept.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                         output logic got, output int edges);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.a     = ~av;
        bus.b     = ~bv;
        got   = 1'b0;
        edges = 0;
        while (!got && edges < 20) begin
            step();
            edges++;
            if (bus.done === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.ena   = 1'b1;
        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        step();
        step();
        n_cmp++;
        if ({bus.busy, bus.done, bus.product, bus.pp_a, bus.pp_b} !== 26'h0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b product=%h pp=%h/%h, want all zero",
                     bus.busy, bus.done, bus.product, bus.pp_a, bus.pp_b);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [7:0] exp_pp [4];
        exp_pp = '{8'h32, 8'h02, 8'h30, 8'h00};
        bus.a     = 8'h03;
        bus.b     = 8'h02;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({bus.pp_a, bus.pp_b} !== exp_pp[i] || bus.busy !== 1'b1) begin
                n_err++;
                $display("FAIL basic_pp%0d: got pp=%h%h busy=%b, want pp=%h busy=1",
                         i, bus.pp_a, bus.pp_b, bus.busy, exp_pp[i]);
            end
            step();
        end
        n_cmp++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.product !== 16'h0006) begin
            n_err++;
            $display("FAIL basic_done: got done=%b busy=%b product=%h, want 1/0/0006",
                     bus.done, bus.busy, bus.product);
        end
        step();
        n_cmp++;
        if (bus.done !== 1'b0 || bus.product !== 16'h0006) begin
            n_err++;
            $display("FAIL basic_done_clear: got done=%b product=%h, want 0/0006",
                     bus.done, bus.product);
        end
    endtask

    task automatic test_extremes();
        logic got;
        int   edges;
        do_op(8'hFF, 8'hFF, got, edges);
        n_cmp++;
        if (got !== 1'b1 || edges != 4 || bus.product !== 16'hFE01) begin
            n_err++;
            $display("FAIL max_operands: got done=%b edges=%0d product=%h, want 1/4/FE01",
                     got, edges, bus.product);
        end
        step();
        do_op(8'h90, 8'h00, got, edges);
        n_cmp++;
        if (got !== 1'b1 || edges != 4 || bus.product !== 16'h0000) begin
            n_err++;
            $display("FAIL zero_operand: got done=%b edges=%0d product=%h, want 1/4/0000",
                     got, edges, bus.product);
        end
        step();
    endtask

    task automatic test_back_to_back();
        bus.a     = 8'h54;
        bus.b     = 8'h23;
        bus.start = 1'b1;
        step();
        bus.a = 8'h0F;
        bus.b = 8'h11;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i < 4) begin
                n_cmp++;
                if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_first_busy%0d: got done=%b busy=%b, want 0/1",
                             i, bus.done, bus.busy);
                end
            end
        end
        n_cmp++;
        if (bus.done !== 1'b1 || bus.product !== 16'h0B7C) begin
            n_err++;
            $display("FAIL b2b_first: got done=%b product=%h, want 1/0B7C",
                     bus.done, bus.product);
        end
        step();
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_reaccept: got done=%b busy=%b, want 0/1", bus.done, bus.busy);
        end
        for (int i = 0; i < 4; i++) step();
        n_cmp++;
        if (bus.done !== 1'b1 || bus.product !== 16'h00FF) begin
            n_err++;
            $display("FAIL b2b_second: got done=%b product=%h, want 1/00FF",
                     bus.done, bus.product);
        end
        bus.start = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        logic got;
        int   edges;
        bus.a     = 8'h12;
        bus.b     = 8'h34;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.product, bus.pp_a, bus.pp_b} !== 26'h0) begin
            n_err++;
            $display("FAIL mid_reset: got busy=%b done=%b product=%h pp=%h/%h, want all zero",
                     bus.busy, bus.done, bus.product, bus.pp_a, bus.pp_b);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                n_err++;
                $display("FAIL mid_reset_quiet%0d: got done=%b busy=%b, want 0/0",
                         i, bus.done, bus.busy);
            end
        end
        do_op(8'h02, 8'h05, got, edges);
        n_cmp++;
        if (got !== 1'b1 || edges != 4 || bus.product !== 16'h000A) begin
            n_err++;
            $display("FAIL after_reset_op: got done=%b edges=%0d product=%h, want 1/4/000A",
                     got, edges, bus.product);
        end
        step();
    endtask

    task automatic test_stall();
        bus.a     = 8'hAB;
        bus.b     = 8'hCD;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        bus.ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0 || {bus.pp_a, bus.pp_b} !== 8'hBC) begin
                n_err++;
                $display("FAIL stall_hold%0d: got busy=%b done=%b pp=%h%h, want 1/0/BC",
                         i, bus.busy, bus.done, bus.pp_a, bus.pp_b);
            end
        end
        bus.ena = 1'b1;
        step();
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL stall_early: got done=%b at edge 6, want 0", bus.done);
        end
        step();
        n_cmp++;
        if (bus.done !== 1'b1 || bus.product !== 16'h88EF) begin
            n_err++;
            $display("FAIL stall_done: got done=%b product=%h at edge 7, want 1/88EF",
                     bus.done, bus.product);
        end
        bus.ena = 1'b0;
        step();
        step();
        n_cmp++;
        if (bus.done !== 1'b1) begin
            n_err++;
            $display("FAIL stall_done_hold: got done=%b while ena=0, want 1", bus.done);
        end
        bus.ena = 1'b1;
        step();
        n_cmp++;
        if (bus.done !== 1'b0 || bus.product !== 16'h88EF) begin
            n_err++;
            $display("FAIL stall_done_clear: got done=%b product=%h, want 0/88EF",
                     bus.done, bus.product);
        end
    endtask

    task automatic test_random();
        logic        got;
        int          edges;
        logic [7:0]  av;
        logic [7:0]  bv;
        logic [15:0] want;
        for (int i = 0; i < 500; i++) begin
            av   = 8'($urandom_range(0, 255));
            bv   = 8'($urandom_range(0, 255));
            want = {8'h00, av} * {8'h00, bv};
            do_op(av, bv, got, edges);
            n_cmp++;
            if (got !== 1'b1 || edges != 4 || bus.product !== want) begin
                n_err++;
                $display("FAIL random_%0d %h*%h: got done=%b edges=%0d product=%h, want 1/4/%h",
                         i, av, bv, got, edges, bus.product, want);
            end
            step();
            n_cmp++;
            if (bus.done !== 1'b0) begin
                n_err++;
                $display("FAIL random_single_done_%0d: got done=%b, want 0", i, bus.done);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_extremes();
        test_back_to_back();
        test_reset_mid();
        test_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
